// File: rtl/param_matrix_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : param_matrix_multiplier
//  Brief    : Runtime-dimensioned unsigned matrix multiplier C = A * B with
//             start/done handshake, dimension checking and overflow flagging.
//             Optional build macro MATMUL_SATURATE_EN: overflowing C elements
//             are written as all ones instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module param_matrix_multiplier #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int MAX_DIM    = 10,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] dim_m,
  input  logic [ADDR_WIDTH-1:0] dim_k,
  input  logic [ADDR_WIDTH-1:0] dim_n,
  output logic                  busy,
  output logic                  done,
  output logic                  dim_error,
  output logic                  en_ReadMat_A,
  output logic [ADDR_WIDTH-1:0] rowAddr_A,
  output logic [ADDR_WIDTH-1:0] colAddr_A,
  input  logic [DATA_WIDTH-1:0] readData_A,
  output logic                  en_ReadMat_B,
  output logic [ADDR_WIDTH-1:0] rowAddr_B,
  output logic [ADDR_WIDTH-1:0] colAddr_B,
  input  logic [DATA_WIDTH-1:0] readData_B,
  output logic                  en_WriteMat_C,
  output logic [ADDR_WIDTH-1:0] rowAddr_C,
  output logic [ADDR_WIDTH-1:0] colAddr_C,
  output logic [DATA_WIDTH-1:0] writeData_C,
  output logic                  resultIsInvalid
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int                    PROD_WIDTH = 2*DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0]   C_MAX_DIM  = (ADDR_WIDTH+1)'(MAX_DIM);
  localparam logic [ADDR_WIDTH-1:0] C_ONE      = ADDR_WIDTH'(1);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] m_q, kd_q, n_q;      // latched dimensions
  logic [ADDR_WIDTH-1:0] i_q, j_q, k_q;       // row, column, inner index
  logic [ACC_WIDTH-1:0]  acc_q;
  logic                  rd_vld_q;            // read data arrives this cycle
  logic                  inv_q;
  logic                  err_q;

  logic                  w_dims_bad;
  logic                  w_k_last, w_j_last, w_i_last;
  logic [PROD_WIDTH-1:0] w_prod;
  logic                  w_ovf;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_fetch, w_write;

  assign w_dims_bad = (m_q == '0) || (kd_q == '0) || (n_q == '0) ||
                      ({1'b0, m_q}  > C_MAX_DIM) ||
                      ({1'b0, kd_q} > C_MAX_DIM) ||
                      ({1'b0, n_q}  > C_MAX_DIM);
  assign w_k_last = (k_q == kd_q - C_ONE);
  assign w_j_last = (j_q == n_q - C_ONE);
  assign w_i_last = (i_q == m_q - C_ONE);
  assign w_prod   = PROD_WIDTH'(readData_A) * PROD_WIDTH'(readData_B);
  // Anything above the low DATA_WIDTH bits means the element does not fit in C.
  assign w_ovf    = |acc_q[ACC_WIDTH-1:DATA_WIDTH];
  assign w_fetch  = (state_q == S_FETCH);
  assign w_write  = (state_q == S_WRITE);

`ifdef MATMUL_SATURATE_EN
  assign w_wdata = w_ovf ? '1 : acc_q[DATA_WIDTH-1:0];
`else
  assign w_wdata = acc_q[DATA_WIDTH-1:0];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CHECK;
      S_CHECK: state_d = w_dims_bad ? S_DONE : S_FETCH;
      S_FETCH: if (w_k_last) state_d = S_DRAIN;
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: state_d = (w_j_last && w_i_last) ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; addresses and data are forced to zero when their strobe is low
  always_comb begin
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    dim_error     = (state_q == S_DONE) && err_q;
    en_ReadMat_A  = w_fetch;
    rowAddr_A     = w_fetch ? i_q : '0;
    colAddr_A     = w_fetch ? k_q : '0;
    en_ReadMat_B  = w_fetch;
    rowAddr_B     = w_fetch ? k_q : '0;
    colAddr_B     = w_fetch ? j_q : '0;
    en_WriteMat_C = w_write;
    rowAddr_C     = w_write ? i_q : '0;
    colAddr_C     = w_write ? j_q : '0;
    writeData_C   = w_write ? w_wdata : '0;
  end

  assign resultIsInvalid = inv_q;

  // Datapath: dimension latch, index counters, MAC accumulator, sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q      <= '0;
      kd_q     <= '0;
      n_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      rd_vld_q <= 1'b0;
      inv_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rd_vld_q <= w_fetch;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            m_q   <= dim_m;
            kd_q  <= dim_k;
            n_q   <= dim_n;
            inv_q <= 1'b0;
            err_q <= 1'b0;
          end
        end
        S_CHECK: begin
          i_q   <= '0;
          j_q   <= '0;
          k_q   <= '0;
          acc_q <= '0;
          err_q <= w_dims_bad;
        end
        S_FETCH: begin
          k_q <= w_k_last ? '0 : k_q + C_ONE;
        end
        S_WRITE: begin
          acc_q <= '0;
          if (w_ovf) inv_q <= 1'b1;
          if (w_j_last) begin
            j_q <= '0;
            i_q <= i_q + C_ONE;
          end else begin
            j_q <= j_q + C_ONE;
          end
        end
        default: ;
      endcase
      // Product of last cycle's read lands one cycle later (FETCH or DRAIN)
      if (rd_vld_q) acc_q <= acc_q + ACC_WIDTH'(w_prod);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_param_matrix_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_matrix_multiplier
//  Brief    : Self-checking bench for param_matrix_multiplier with memory
//             models for A/B/C and an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_param_matrix_multiplier;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] dim_m, dim_k, dim_n;
  logic          busy, done, dim_error;
  logic          en_ReadMat_A, en_ReadMat_B, en_WriteMat_C;
  logic [AW-1:0] rowAddr_A, colAddr_A, rowAddr_B, colAddr_B, rowAddr_C, colAddr_C;
  logic [DW-1:0] readData_A, readData_B, writeData_C;
  logic          resultIsInvalid;

  param_matrix_multiplier #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_DIM(10)) dut (
    .clk(clk), .reset(reset), .start(start),
    .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
    .busy(busy), .done(done), .dim_error(dim_error),
    .en_ReadMat_A(en_ReadMat_A), .rowAddr_A(rowAddr_A), .colAddr_A(colAddr_A),
    .readData_A(readData_A),
    .en_ReadMat_B(en_ReadMat_B), .rowAddr_B(rowAddr_B), .colAddr_B(colAddr_B),
    .readData_B(readData_B),
    .en_WriteMat_C(en_WriteMat_C), .rowAddr_C(rowAddr_C), .colAddr_C(colAddr_C),
    .writeData_C(writeData_C), .resultIsInvalid(resultIsInvalid)
  );

  always #5 clk = ~clk;

  int memA [16][16];
  int memB [16][16];
  int expC [16][16];
  int expInv;

  // Synchronous read memories; junk is returned when not strobed
  always @(posedge clk) begin
    if (en_ReadMat_A) readData_A <= DW'(memA[rowAddr_A][colAddr_A]);
    else              readData_A <= DW'($urandom);
    if (en_ReadMat_B) readData_B <= DW'(memB[rowAddr_B][colAddr_B]);
    else              readData_B <= DW'($urandom);
  end

  typedef struct { int r; int c; int d; } wr_t;
  wr_t wq[$];
  int  rdA_cnt = 0, rdB_cnt = 0, addr_viol = 0;

  // Monitor: C write log, read strobe counts, address-zero rule
  always @(negedge clk) begin
    if (en_WriteMat_C) wq.push_back('{int'(rowAddr_C), int'(colAddr_C), int'(writeData_C)});
    if (en_ReadMat_A) rdA_cnt++;
    if (en_ReadMat_B) rdB_cnt++;
    if (!reset) begin
      if (!en_ReadMat_A && (rowAddr_A != '0 || colAddr_A != '0)) addr_viol++;
      if (!en_ReadMat_B && (rowAddr_B != '0 || colAddr_B != '0)) addr_viol++;
      if (!en_WriteMat_C && (rowAddr_C != '0 || colAddr_C != '0 || writeData_C != '0)) addr_viol++;
    end
  end

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  function automatic int outs_ones();
    return $countones({busy, done, dim_error, en_ReadMat_A, rowAddr_A, colAddr_A,
                       en_ReadMat_B, rowAddr_B, colAddr_B, en_WriteMat_C,
                       rowAddr_C, colAddr_C, writeData_C, resultIsInvalid});
  endfunction

  typedef struct { int m; int k; int n; int pat; int exp_done; int exp_err; int exp_inv; } vec_t;

  task automatic fill(input int pat, input int m, input int k, input int n);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        memA[r][c] = int'($urandom_range(0, 255));
        memB[r][c] = int'($urandom_range(0, 255));
      end
    case (pat)
      0: begin
        memA[0][0] = 1; memA[0][1] = 2; memA[1][0] = 3; memA[1][1] = 4;
        memB[0][0] = 1; memB[0][1] = 0; memB[1][0] = 0; memB[1][1] = 1;
      end
      1: begin
        memA[0][0] = 1; memA[0][1] = 2; memA[0][2] = 3;
        memB[0][0] = 1; memB[0][1] = 0; memB[1][0] = 0; memB[1][1] = 1;
        memB[2][0] = 1; memB[2][1] = 1;
      end
      2: begin memA[0][0] = 16; memB[0][0] = 16; end
      3: begin
        for (int r = 0; r < m; r++) for (int c = 0; c < k; c++) memA[r][c] = int'($urandom_range(0, 4));
        for (int r = 0; r < k; r++) for (int c = 0; c < n; c++) memB[r][c] = int'($urandom_range(0, 4));
      end
      default: ;
    endcase
  endtask

  // Reference: plain dot products, then the element policy for values above 255
  task automatic model(input int m, input int k, input int n);
    int s;
    expInv = 0;
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int kk = 0; kk < k; kk++) s += memA[i][kk] * memB[kk][j];
        if (s > 255) begin
          expInv = 1;
`ifdef MATMUL_SATURATE_EN
          expC[i][j] = 255;
`else
          expC[i][j] = s % 256;
`endif
        end else begin
          expC[i][j] = s;
        end
      end
  endtask

  task automatic run_vec(input vec_t v, input int poke);
    int w0, ra0, rb0, cy, nexp, inv_exp, legal, nwr;
    legal = (v.exp_err == 0) ? 1 : 0;
    fill(v.pat, v.m, v.k, v.n);
    if (legal == 1) model(v.m, v.k, v.n);
    inv_exp = (v.exp_inv < 0) ? expInv : v.exp_inv;
    w0 = wq.size(); ra0 = rdA_cnt; rb0 = rdB_cnt;
    @(negedge clk);
    start = 1'b1; dim_m = AW'(v.m); dim_k = AW'(v.k); dim_n = AW'(v.n);
    @(negedge clk);
    cy = 1;
    while (!done && cy < 3000) begin
      start = (cy == poke);
      if (cy == poke) begin dim_m = 1; dim_k = 1; dim_n = 1; end
      @(negedge clk);
      cy++;
    end
    start = 1'b0;
    chk("done_seen", int'(done), 1);
    chk("done_cycle", cy, v.exp_done);
    chk("dim_error", int'(dim_error), v.exp_err);
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    chk("result_invalid", int'(resultIsInvalid), inv_exp);
    nexp = (legal == 1) ? v.m * v.n : 0;
    nwr  = wq.size() - w0;
    chk("write_count", nwr, nexp);
    chk("readA_count", rdA_cnt - ra0, nexp * v.k);
    chk("readB_count", rdB_cnt - rb0, nexp * v.k);
    for (int e = 0; e < nexp && e < nwr; e++) begin
      chk("c_elem(row*65536+col*256+data)",
          wq[w0+e].r * 65536 + wq[w0+e].c * 256 + wq[w0+e].d,
          (e / v.n) * 65536 + (e % v.n) * 256 + expC[e / v.n][e % v.n]);
    end
  endtask

  vec_t vt[12];

  initial begin
    int m, k, n;
    reset = 1'b1; start = 1'b0; dim_m = '0; dim_k = '0; dim_n = '0;

    vt[0] = '{2, 2, 2, 0, 18, 0, 0};
    vt[1] = '{1, 3, 2, 1, 12, 0, 0};
    vt[2] = '{1, 1, 1, 2, 5, 0, 1};
    vt[3] = '{2, 0, 2, 4, 2, 1, 0};
    vt[4] = '{11, 2, 2, 4, 2, 1, 0};
    vt[5] = '{3, 3, 15, 4, 2, 1, 0};
    vt[6] = '{10, 10, 10, 3, 1202, 0, 0};
    vt[7] = '{10, 1, 10, 4, 302, 0, -1};
    for (int t = 8; t < 12; t++) begin
      m = int'($urandom_range(1, 10)); k = int'($urandom_range(1, 10)); n = int'($urandom_range(1, 10));
      vt[t] = '{m, k, n, 4, 2 + m * n * (k + 2), 0, -1};
    end

    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", outs_ones(), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 12; t++) run_vec(vt[t], -1);

    // start pulsed mid-FETCH with different dims must be ignored
    run_vec(vt[0], 6);

    // reset asserted in the middle of a long run
    fill(3, 10, 10, 10);
    @(negedge clk);
    start = 1'b1; dim_m = 10; dim_k = 10; dim_n = 10;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_mid_fetch", int'(busy), 1);
    chk("read_strobe_mid_fetch", int'(en_ReadMat_A), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_outputs_zero", outs_ones(), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_reset_outputs_zero", outs_ones(), 0);
    run_vec(vt[0], -1);

    chk("zero_addr_when_no_strobe", addr_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/param_matrix_multiplier.md
# param_matrix_multiplier

Runtime-dimensioned unsigned integer matrix multiplier computing C[M×N] = A[M×K] · B[K×N]. It generalises the fixed 10×10 multiplier to any M, K, N up to MAX_DIM, with a start/done handshake, dimension checking and a selectable overflow policy. It sits between three external single-port matrix memories (A, B read-only; C write-only) and a controller that programs dimensions and pulses start.

## Interface

- DATA_WIDTH, 8, element width of A, B and C (unsigned)
- ADDR_WIDTH, 4, width of row/column addresses and dimension inputs
- MAX_DIM, 10, largest legal value of M, K, N (≤ 2^ADDR_WIDTH)
- ACC_WIDTH, 2*DATA_WIDTH+ADDR_WIDTH, internal accumulator width; never overflows

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- dim_m, dim_k, dim_n  in  ADDR_WIDTH  each  matrix dimensions, sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- dim_error  out  1  one-cycle pulse with done when dimensions were illegal
- en_ReadMat_A  out  1  read strobe for A
- rowAddr_A, colAddr_A  out  ADDR_WIDTH  each  A address (i, k)
- readData_A  in  DATA_WIDTH  A data, valid the cycle after en_ReadMat_A
- en_ReadMat_B  out  1  read strobe for B
- rowAddr_B, colAddr_B  out  ADDR_WIDTH  each  B address (k, j)
- readData_B  in  DATA_WIDTH  B data, valid the cycle after en_ReadMat_B
- en_WriteMat_C  out  1  one-cycle write strobe for C
- rowAddr_C, colAddr_C  out  ADDR_WIDTH  each  C address (i, j)
- writeData_C  out  DATA_WIDTH  C element
- resultIsInvalid  out  1  sticky: some C element exceeded 2^DATA_WIDTH−1

## Operation

- States: IDLE, CHECK, FETCH, DRAIN, WRITE, DONE.
- IDLE: start=1 latches dims, clears resultIsInvalid, goes to CHECK. start in any other state is ignored.
- CHECK (1 cycle): any dim equal to 0 or > MAX_DIM → DONE with dim_error; else i=j=k=0, acc=0, → FETCH. No memory strobes issued on error.
- FETCH: en_ReadMat_A=en_ReadMat_B=1, addresses A(i,k), B(k,j); k increments each cycle; after k=K−1 → DRAIN.
- MAC: each cycle after a read, acc += readData_A*readData_B (full 2·DATA_WIDTH product, ACC_WIDTH sum).
- DRAIN (1 cycle): absorbs the final product.
- WRITE (1 cycle): en_WriteMat_C=1 at (i,j); acc cleared; j increments, wrapping to 0 with i increment; after (M−1,N−1) → DONE, else → FETCH with k=0.
- Overflow: acc > 2^DATA_WIDTH−1 at WRITE sets resultIsInvalid (held until next accepted start or reset).
- DONE (1 cycle): done=1, dim_error as determined; → IDLE.
- C written in strict row-major order, each element exactly once.
- Reset value of every output: 0. Reset mid-operation: next edge returns to IDLE, no further strobes, partial C contents undefined.
- Address outputs are 0 whenever their strobe is low.

## Timing

- Start sampled at edge e0; CHECK in cycle 1; first FETCH in cycle 2.
- Per element: K FETCH + 1 DRAIN + 1 WRITE = K+2 cycles.
- done asserted in cycle 2 + M·N·(K+2); busy falls the cycle after.
- Illegal dims: done and dim_error in cycle 2.
- Read latency fixed at 1 cycle; memories must return data for every strobe.

## Configuration

- MATMUL_SATURATE_EN defined: overflowing element written as all ones (2^DATA_WIDTH−1).
- Undefined: overflowing element written as acc[DATA_WIDTH−1:0] (wrap). resultIsInvalid behaviour is identical in both builds.

## Test plan

- M=K=N=2, A=[[1,2],[3,4]], B=identity → C writes (0,0)=1,(0,1)=2,(1,0)=3,(1,1)=4 in that order; done in cycle 18; resultIsInvalid=0.
- M=1,K=3,N=2, A=[1,2,3], B=[[1,0],[0,1],[1,1]] → C=[4,5]; done in cycle 12.
- M=K=N=1, A=B=16 → resultIsInvalid=1; writeData_C=255 with MATMUL_SATURATE_EN, 0 without.
- M=K=N=10, random elements 0..4 → all 100 C entries match golden model; done in cycle 1202; resultIsInvalid=0.
- dim_k=0 (then dim_m=11) → done+dim_error in cycle 2, no read/write strobes.
- start pulsed while busy → ignored; reset asserted mid-FETCH → all outputs 0 next cycle, IDLE, new start runs cleanly.
